proc_control: RTL and testbench



---
 rtl/proc_control_if.sv | 26 ++
 rtl/proc_control.sv | 128 ++++++++++++
 tb/tb_proc_control.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/proc_control_if.sv
// Run/IR handshake and datapath strobe bundle between proc_control and the
// 16-bit bus datapath.
interface proc_control_if;
  logic        Run;
  logic [15:0] IR;
  logic        IRin;
  logic [7:0]  Rin;
  logic [7:0]  Rout;
  logic        Gout;
  logic        DINout;
  logic        Ain;
  logic        Gin;
  logic [2:0]  AluOp;
  logic        Done;
  logic [1:0]  Tstep;

  modport master (
    input  Run, IR,
    output IRin, Rin, Rout, Gout, DINout, Ain, Gin, AluOp, Done, Tstep
  );

  modport slave (
    output Run, IR,
    input  IRin, Rin, Rout, Gout, DINout, Ain, Gin, AluOp, Done, Tstep
  );
endinterface

// File: rtl/proc_control.sv
// Control unit for the 16-bit bus processor: time-step FSM plus instruction
// decode that drives every datapath strobe combinationally.
module proc_control (
  input  logic           Clock,
  input  logic           Resetn,
  proc_control_if.master bus
);
  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } tstep_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;

  tstep_e     r_state;
  tstep_e     w_next;
  logic [2:0] w_op;
  logic [2:0] w_x;
  logic [2:0] w_y;
  logic [7:0] w_x_dec;
  logic [7:0] w_y_dec;
  logic       w_irin;
  logic [7:0] w_rin;
  logic [7:0] w_rout;
  logic       w_gout;
  logic       w_dinout;
  logic       w_ain;
  logic       w_gin;
  logic [2:0] w_aluop;
  logic       w_done;
  logic       w_unused_ir;

  function automatic logic [7:0] dec3(input logic [2:0] idx);
    dec3 = 8'b0000_0001 << idx;
  endfunction

  assign w_op        = bus.IR[15:13];
  assign w_x         = bus.IR[12:10];
  assign w_y         = bus.IR[9:7];
  assign w_x_dec     = dec3(w_x);
  assign w_y_dec     = dec3(w_y);
  assign w_unused_ir = ^bus.IR[6:0];

  // time-step register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= T0;
    end else begin
      r_state <= w_next;
    end
  end

  // next-step and strobe decode
  always_comb begin
    w_next   = r_state;
    w_irin   = 1'b0;
    w_rin    = 8'h00;
    w_rout   = 8'h00;
    w_gout   = 1'b0;
    w_dinout = 1'b0;
    w_ain    = 1'b0;
    w_gin    = 1'b0;
    w_aluop  = 3'b000;
    w_done   = 1'b0;
    case (r_state)
      T0: begin
        w_irin = bus.Run;
        if (bus.Run) begin
          w_next = T1;
        end else begin
          w_next = T0;
        end
      end
      T1: begin
        if (w_op == OP_MV) begin
          w_rout = w_y_dec;
          w_rin  = w_x_dec;
          w_done = 1'b1;
          w_next = T0;
        end else if (w_op == OP_MVI) begin
          w_dinout = 1'b1;
          w_rin    = w_x_dec;
          w_done   = 1'b1;
          w_next   = T0;
        end else begin
          w_rout = w_x_dec;
          w_ain  = 1'b1;
          w_next = T2;
        end
      end
      T2: begin
        // mv/mvi never reach T2 while IR is stable; fall back to T0 silently
        if ((w_op == OP_MV) || (w_op == OP_MVI)) begin
          w_next = T0;
        end else begin
          w_rout  = w_y_dec;
          w_gin   = 1'b1;
          w_aluop = w_op - 3'd2;
          w_next  = T3;
        end
      end
      T3: begin
        w_gout = 1'b1;
        w_rin  = w_x_dec;
        w_done = 1'b1;
        w_next = T0;
      end
      default: begin
        w_next = T0;
      end
    endcase
  end

  // reset forces every output low regardless of Run
  assign bus.IRin   = Resetn & w_irin;
  assign bus.Rin    = Resetn ? w_rin  : 8'h00;
  assign bus.Rout   = Resetn ? w_rout : 8'h00;
  assign bus.Gout   = Resetn & w_gout;
  assign bus.DINout = Resetn & w_dinout;
  assign bus.Ain    = Resetn & w_ain;
  assign bus.Gin    = Resetn & w_gin;
  assign bus.AluOp  = Resetn ? w_aluop : 3'b000;
  assign bus.Done   = Resetn & w_done;
  assign bus.Tstep  = Resetn ? r_state : 2'b00;
endmodule

// File: tb/tb_proc_control.sv
// Scoreboard bench for proc_control with a small behavioural datapath
// (IR, R0-R7, A, G, ALU, bus mux) driven by the DUT strobes.
module tb_proc_control;
  typedef struct packed {
    logic [1:0] t;
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic [2:0] op;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] val;
  } wr_t;

  logic        Clock  = 1'b0;
  logic        Resetn = 1'b1;
  logic [15:0] DIN    = 16'h0000;
  logic [15:0] r_ir   = 16'h0000;
  logic [15:0] r_reg [8];
  logic [15:0] r_a;
  logic [15:0] r_g;
  logic [15:0] w_bus;
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n_vec  = 0;
  exp_t        sb [$];
  wr_t         wq [$];
  exp_t        mon_e;
  exp_t        mon_a;
  wr_t         mon_w;

  proc_control_if bus ();
  assign bus.IR = r_ir;

  proc_control dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus.master)
  );

  always #5 Clock = ~Clock;

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000:  alu = a + b;
      3'b001:  alu = a - b;
      3'b010:  alu = a | b;
      3'b011:  alu = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      3'b100:  alu = a << b[3:0];
      3'b101:  alu = a >> b[3:0];
      default: alu = 16'h0000;
    endcase
  endfunction

  always_comb begin
    w_bus = 16'h0000;
    if (bus.DINout) begin
      w_bus = DIN;
    end else if (bus.Gout) begin
      w_bus = r_g;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.Rout[i]) w_bus = r_reg[i];
      end
    end
  end

  always @(posedge Clock) begin
    if (bus.IRin) r_ir <= DIN;
    if (bus.Ain)  r_a  <= w_bus;
    if (bus.Gin)  r_g  <= alu(bus.AluOp, r_a, w_bus);
    for (int k = 0; k < 8; k++) begin
      if (bus.Rin[k]) r_reg[k] <= w_bus;
    end
  end

  // monitor: per-cycle strobe vector, bus invariants, and register write at Done
  always @(negedge Clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_a = {bus.Tstep, bus.IRin, bus.Rin, bus.Rout, bus.Gout, bus.DINout,
               bus.Ain, bus.Gin, bus.AluOp, bus.Done};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_err++;
        $display("FAIL strobes vec%0d: actual t=%b irin=%b rin=%b rout=%b gout=%b dinout=%b ain=%b gin=%b op=%b done=%b required t=%b irin=%b rin=%b rout=%b gout=%b dinout=%b ain=%b gin=%b op=%b done=%b",
                 n_vec, mon_a.t, mon_a.irin, mon_a.rin, mon_a.rout, mon_a.gout, mon_a.dinout,
                 mon_a.ain, mon_a.gin, mon_a.op, mon_a.done,
                 mon_e.t, mon_e.irin, mon_e.rin, mon_e.rout, mon_e.gout, mon_e.dinout,
                 mon_e.ain, mon_e.gin, mon_e.op, mon_e.done);
      end
      n_vec++;
    end
    n_cmp++;
    if (($countones({bus.Rout, bus.Gout, bus.DINout}) > 1) || ($countones(bus.Rin) > 1)) begin
      n_err++;
      $display("FAIL invariant: actual rout=%b gout=%b dinout=%b rin=%b required at most one driver and one Rin",
               bus.Rout, bus.Gout, bus.DINout, bus.Rin);
    end
    if (bus.Done === 1'b1) begin
      n_cmp++;
      if (wq.size() == 0) begin
        n_err++;
        $display("FAIL done: actual Done=1 required no Done (no instruction pending)");
      end else begin
        mon_w = wq.pop_front();
        if ((bus.Rin !== (8'b0000_0001 << mon_w.idx)) || (w_bus !== mon_w.val)) begin
          n_err++;
          $display("FAIL write: actual rin=%b bus=%h required rin=%b bus=%h",
                   bus.Rin, w_bus, 8'b0000_0001 << mon_w.idx, mon_w.val);
        end
      end
    end
  end

  function automatic exp_t e_idle();
    e_idle = '0;
  endfunction

  function automatic exp_t e_fetch();
    e_fetch = '0;
    e_fetch.irin = 1'b1;
  endfunction

  function automatic exp_t e_mv(input logic [2:0] x, input logic [2:0] y);
    e_mv = '0;
    e_mv.t = 2'b01; e_mv.rout = 8'b0000_0001 << y; e_mv.rin = 8'b0000_0001 << x; e_mv.done = 1'b1;
  endfunction

  function automatic exp_t e_mvi(input logic [2:0] x);
    e_mvi = '0;
    e_mvi.t = 2'b01; e_mvi.dinout = 1'b1; e_mvi.rin = 8'b0000_0001 << x; e_mvi.done = 1'b1;
  endfunction

  function automatic exp_t e_a1(input logic [2:0] x);
    e_a1 = '0;
    e_a1.t = 2'b01; e_a1.rout = 8'b0000_0001 << x; e_a1.ain = 1'b1;
  endfunction

  function automatic exp_t e_a2(input logic [2:0] y, input logic [2:0] aluop);
    e_a2 = '0;
    e_a2.t = 2'b10; e_a2.rout = 8'b0000_0001 << y; e_a2.gin = 1'b1; e_a2.op = aluop;
  endfunction

  function automatic exp_t e_a3(input logic [2:0] x);
    e_a3 = '0;
    e_a3.t = 2'b11; e_a3.gout = 1'b1; e_a3.rin = 8'b0000_0001 << x; e_a3.done = 1'b1;
  endfunction

  task automatic step(input logic rstn, input logic run, input logic [15:0] din, input exp_t e);
    @(posedge Clock);
    #1;
    Resetn  = rstn;
    bus.Run = run;
    DIN     = din;
    sb.push_back(e);
  endtask

  task automatic wexp(input logic [2:0] idx, input logic [15:0] val);
    wr_t w;
    w.idx = idx;
    w.val = val;
    wq.push_back(w);
  endtask

  task automatic do_mvi(input logic [2:0] x, input logic [15:0] val);
    step(1'b1, 1'b1, {3'b001, x, 10'b0}, e_fetch());
    step(1'b1, 1'b1, val, e_mvi(x));
    wexp(x, val);
  endtask

  task automatic do_mv(input logic [2:0] x, input logic [2:0] y, input logic [15:0] val);
    step(1'b1, 1'b1, {3'b000, x, y, 7'b0}, e_fetch());
    step(1'b1, 1'b1, 16'h0000, e_mv(x, y));
    wexp(x, val);
  endtask

  task automatic do_alu(input logic [2:0] op, input logic [2:0] aluop, input logic [2:0] x,
                        input logic [2:0] y, input logic [15:0] val);
    step(1'b1, 1'b1, {op, x, y, 7'b0}, e_fetch());
    step(1'b1, 1'b1, 16'h0000, e_a1(x));
    step(1'b1, 1'b1, 16'h0000, e_a2(y, aluop));
    step(1'b1, 1'b1, 16'h0000, e_a3(x));
    wexp(x, val);
  endtask

  initial begin
    bus.Run = 1'b1;
    Resetn  = 1'b0;
    step(1'b0, 1'b1, 16'h0000, e_idle());
    step(1'b0, 1'b1, 16'h0000, e_idle());
    repeat (5) step(1'b1, 1'b0, 16'h0000, e_idle());

    do_mvi(3'd3, 16'h1234);
    step(1'b1, 1'b0, 16'h0000, e_idle());
    do_mv(3'd5, 3'd3, 16'h1234);
    step(1'b1, 1'b0, 16'h0000, e_idle());

    // Run held high from here through every ALU op: no idle cycles
    do_mvi(3'd0, 16'h0005);
    do_mvi(3'd1, 16'h0007);
    do_alu(3'b010, 3'b000, 3'd0, 3'd1, 16'h000C);
    do_alu(3'b110, 3'b100, 3'd0, 3'd1, 16'h0600);
    do_alu(3'b111, 3'b101, 3'd0, 3'd1, 16'h000C);
    do_alu(3'b011, 3'b001, 3'd0, 3'd1, 16'h0005);
    do_alu(3'b101, 3'b011, 3'd0, 3'd1, 16'h0001);
    do_alu(3'b100, 3'b010, 3'd0, 3'd1, 16'h0007);
    step(1'b1, 1'b0, 16'h0000, e_idle());

    // add R0,R1 aborted by reset in T2; R0 must keep 7
    step(1'b1, 1'b1, 16'h4080, e_fetch());
    step(1'b1, 1'b1, 16'h0000, e_a1(3'd0));
    step(1'b0, 1'b1, 16'h0000, e_idle());
    step(1'b0, 1'b1, 16'h0000, e_idle());
    do_mv(3'd2, 3'd0, 16'h0007);
    do_mv(3'd2, 3'd2, 16'h0007);
    step(1'b1, 1'b0, 16'h0000, e_idle());

    repeat (3) @(negedge Clock);
    #1;
    n_cmp++;
    if ((sb.size() != 0) || (wq.size() != 0)) begin
      n_err++;
      $display("FAIL drain: actual pending strobes=%0d writes=%0d required 0 and 0", sb.size(), wq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
